// File: rtl/pe_rr_arb.sv
// Round-robin single-grant arbiter with a valid/ready handshake toward the consumer.
// Optional PE_RR_ARB_STICKY_EN holds an offered grant stable under backpressure.
module pe_rr_arb #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned INDEX_W = $clog2(WIDTH)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [WIDTH-1:0]   req_vec,
   output logic               ack_valid,
   input  logic               ack_ready,
   output logic [WIDTH-1:0]   ack_one_hot,
   output logic [INDEX_W-1:0] ack_index,
   output logic               ack_wrapped
);

   localparam logic [WIDTH-1:0] LOne = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]   r_rr_mask;
   logic [WIDTH-1:0]   w_masked;
   logic [WIDTH-1:0]   w_masked_lsb;
   logic [WIDTH-1:0]   w_req_lsb;
   logic [WIDTH-1:0]   w_grant;
   logic [WIDTH-1:0]   w_cold_mask;
   logic [INDEX_W-1:0] w_index;
   logic               w_valid;
   logic               w_wrapped;
   logic               w_accept;

   assign w_masked     = req_vec & r_rr_mask;
   // Two's-complement trick isolates the lowest set bit.
   assign w_masked_lsb = w_masked & (~w_masked + LOne);
   assign w_req_lsb    = req_vec & (~req_vec + LOne);
   assign w_valid      = |req_vec;

`ifdef PE_RR_ARB_STICKY_EN
   logic             r_hold_v;
   logic [WIDTH-1:0] r_hold_oh;
   logic             w_force;

   assign w_force = r_hold_v && ((req_vec & r_hold_oh) != '0);

   always_comb begin
      w_grant   = '0;
      w_wrapped = 1'b0;
      if (w_force) begin
         w_grant = r_hold_oh;
      end else if (w_masked != '0) begin
         w_grant = w_masked_lsb;
      end else if (w_valid) begin
         w_grant   = w_req_lsb;
         w_wrapped = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_hold_v  <= 1'b0;
         r_hold_oh <= '0;
      end else if (w_valid && !ack_ready) begin
         r_hold_v  <= 1'b1;
         r_hold_oh <= w_grant;
      end else begin
         r_hold_v  <= 1'b0;
      end
   end
`else
   always_comb begin
      w_grant   = '0;
      w_wrapped = 1'b0;
      if (w_masked != '0) begin
         w_grant = w_masked_lsb;
      end else if (w_valid) begin
         w_grant   = w_req_lsb;
         w_wrapped = 1'b1;
      end
   end
`endif

   always_comb begin
      w_index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_grant[i]) begin
            w_index = w_index | INDEX_W'(i);
         end
      end
   end

   // Clear the granted bit and everything below it; granting the MSB yields all zero.
   assign w_cold_mask = ~(w_grant | (w_grant - LOne));
   assign w_accept    = w_valid & ack_ready;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rr_mask <= '1;
      end else if (w_accept) begin
         r_rr_mask <= w_cold_mask;
      end
   end

   assign ack_valid   = w_valid;
   assign ack_one_hot = w_grant;
   assign ack_index   = w_index;
   assign ack_wrapped = w_wrapped;

endmodule

// File: tb/tb_pe_rr_arb.sv
// Directed self-checking bench for pe_rr_arb (WIDTH=8); covers both PE_RR_ARB_STICKY_EN builds.
module tb_pe_rr_arb;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] req_vec;
   logic       ack_valid;
   logic       ack_ready;
   logic [7:0] ack_one_hot;
   logic [2:0] ack_index;
   logic       ack_wrapped;

   int checks = 0;
   int errors = 0;

   pe_rr_arb #(.WIDTH(8)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .req_vec     (req_vec),
      .ack_valid   (ack_valid),
      .ack_ready   (ack_ready),
      .ack_one_hot (ack_one_hot),
      .ack_index   (ack_index),
      .ack_wrapped (ack_wrapped)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then check the combinational outputs.
   task automatic step(input string tag, input logic rst, input logic [7:0] req,
                       input logic rdy, input logic ev, input int ei, input logic ew);
      logic [7:0] eoh;
      @(negedge CLK);
      RST       = rst;
      req_vec   = req;
      ack_ready = rdy;
      #1;
      eoh = ev ? (8'd1 << ei) : 8'd0;
      chk({tag, ".valid"},   64'(ack_valid),   64'(ev));
      chk({tag, ".index"},   64'(ack_index),   64'(ev ? ei : 0));
      chk({tag, ".onehot"},  64'(ack_one_hot), 64'(eoh));
      chk({tag, ".wrapped"}, 64'(ack_wrapped), 64'(ew));
   endtask

   initial begin
      RST       = 1'b1;
      req_vec   = 8'h00;
      ack_ready = 1'b0;

      // Reset with no requests: every output reads zero.
      step("rst_idle", 1, 8'h00, 1, 0, 0, 0);
      step("rst_ff",   1, 8'hFF, 1, 1, 0, 0);

      // Full rotation with every requester active.
      step("rot0", 0, 8'hFF, 1, 1, 0, 0);
      step("rot1", 0, 8'hFF, 1, 1, 1, 0);
      step("rot2", 0, 8'hFF, 1, 1, 2, 0);
      step("rot3", 0, 8'hFF, 1, 1, 3, 0);
      step("rot4", 0, 8'hFF, 1, 1, 4, 0);
      step("rot5", 0, 8'hFF, 1, 1, 5, 0);
      step("rot6", 0, 8'hFF, 1, 1, 6, 0);
      step("rot7", 0, 8'hFF, 1, 1, 7, 0);
      step("rot8", 0, 8'hFF, 1, 1, 0, 1);
      step("rot9", 0, 8'hFF, 1, 1, 1, 0);

      // Alternating end bits; MSB accept leaves an all-zero mask.
      step("alt_rst", 1, 8'h00, 0, 0, 0, 0);
      step("alt0", 0, 8'h81, 1, 1, 0, 0);
      step("alt1", 0, 8'h81, 1, 1, 7, 0);
      step("alt2", 0, 8'h81, 1, 1, 0, 1);
      step("alt3", 0, 8'h81, 1, 1, 7, 0);

      // Accept 3 from a zero mask, then a lower request must wrap.
      step("acc3",  0, 8'h08, 1, 1, 3, 1);
      step("wrap1", 0, 8'h06, 0, 1, 1, 1);

      // Backpressure holds grant 4 and the mask.
      step("bp0", 0, 8'h30, 0, 1, 4, 0);
      step("bp1", 0, 8'h30, 0, 1, 4, 0);
      step("bp2", 0, 8'h30, 0, 1, 4, 0);
      step("bp3", 0, 8'h30, 0, 1, 4, 0);
      step("bp_acc", 0, 8'h30, 1, 1, 4, 0);
      step("bp_next", 0, 8'h30, 0, 1, 5, 0);

      // Backpressured grant 5 while a favoured request 2 appears.
      step("st_rst", 1, 8'h00, 0, 0, 0, 0);
      step("st_acc1", 0, 8'h02, 1, 1, 1, 0);
      step("st_off5", 0, 8'h20, 0, 1, 5, 0);
`ifdef PE_RR_ARB_STICKY_EN
      step("st_hold", 0, 8'h24, 0, 1, 5, 0);
      step("st_acc",  0, 8'h24, 1, 1, 5, 0);
      step("st_after", 0, 8'h24, 0, 1, 2, 1);
`else
      step("st_swap", 0, 8'h24, 0, 1, 2, 0);
      step("st_acc",  0, 8'h24, 1, 1, 2, 0);
      step("st_after", 0, 8'h24, 0, 1, 5, 0);
`endif

      // Reset wins over a simultaneous accept of index 6.
      step("rst_acc6", 1, 8'h40, 1, 1, 6, 0);
      step("post_rst", 0, 8'hFF, 0, 1, 0, 0);
      step("idle",     0, 8'h00, 1, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_rr_arb.md
Name: pe_rr_arb

Overview:
- Parametrised round-robin arbiter; stateful successor to the LSB-first priority encoder.
- Picks one requester per cycle, LSB-first starting just above the last accepted index, wrapping to bit 0.
- valid/ready handshake toward the consumer; pointer advances only on accept.
- Used wherever issue queues, LSQ ports or writeback muxes need fair single-grant selection among WIDTH requesters.

Parameters:
- WIDTH, 8, number of requesters; legal range 2..64.
- INDEX_W, $clog2(WIDTH), width of the ack_index output (derived; do not override).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous active-high reset.
- req_vec  input  WIDTH  request bit per requester.
- ack_valid  output  1  |req_vec; a grant is offered this cycle.
- ack_ready  input  1  consumer accepts the offered grant this cycle.
- ack_one_hot  output  WIDTH  one-hot grant; all zero when ack_valid=0.
- ack_index  output  INDEX_W  binary index of the grant; 0 when ack_valid=0.
- ack_wrapped  output  1  grant came from the unmasked (wrap-around) search.

Behaviour:
- State rr_mask_q[WIDTH-1:0] holds the bits eligible for first-pass priority. Reset value is all ones, so the first grant is plain LSB-first.
- Grant selection is combinational, zero latency from req_vec:
  - masked = req_vec & rr_mask_q.
  - If masked != 0, grant the LSB of masked and drive ack_wrapped=0.
  - Else, if req_vec != 0, grant the LSB of req_vec and drive ack_wrapped=1.
  - Else drive ack_valid=0, ack_one_hot=0, ack_index=0, ack_wrapped=0.
- Accept = ack_valid & ack_ready. On accept of index j, rr_mask_q <= bits strictly above j set, bits 0..j clear (the cold mask of the grant).
- When j = WIDTH-1 the next mask is all zero. The next grant then comes from the wrap search; this is legal and required.
- No accept (ack_ready=0 or ack_valid=0): rr_mask_q holds.
- ack_ready while ack_valid=0 is ignored; no state change.
- Outputs are purely combinational from req_vec, rr_mask_q and the sticky state. They carry no reset value of their own: with RST=1 and req_vec=0 every output reads 0.
- Reset mid-operation: RST in any cycle forces rr_mask_q to all ones and clears the sticky state on the next edge. An accept in the same cycle as RST is discarded (reset wins).
- Fairness: with all requests held high and ack_ready=1 every cycle, the grant sequence is 0,1,...,WIDTH-1,0,...
  - Any requester continuously asserted is granted within WIDTH accepts.

Optional Feature:
- Macro PE_RR_ARB_STICKY_EN.
- Defined:
  - Adds registers hold_v_q (reset 0) and hold_oh_q[WIDTH-1:0] (reset 0).
  - If ack_valid & !ack_ready, next edge: hold_v_q <= 1, hold_oh_q <= ack_one_hot.
  - While hold_v_q=1 and (req_vec & hold_oh_q) != 0, the grant is forced to hold_oh_q, overriding round-robin. ack_wrapped=0 during a forced grant.
  - If the held request drops, arbitration resumes normally that same cycle, and hold_v_q clears at the next edge unless a new stall occurs.
  - Accept clears hold_v_q.
  - Guarantees the offered grant never changes under backpressure while its request persists.
- Undefined:
  - No hold registers.
  - Under backpressure the grant is recomputed each cycle, so a newly raised higher-priority request may replace the offered grant.

Test Plan:
- RST=1, req_vec=8'hFF, then release; ack_ready=1 for 10 cycles -> ack_index sequence 0,1,2,3,4,5,6,7,0,1; ack_wrapped=1 only on the grants to index 0 after the first (cycles 9 and 10 grant 0 and 1 respectively; only the index-0 grant shows wrap).
- req_vec=8'b1000_0001, ack_ready=1 -> grants 0,7,0,7 alternate; mask after the index-7 accept is 0 and the next grant has ack_wrapped=1.
- Accept index 3 (mask becomes 8'b1111_0000), then req_vec=8'b0000_0110 -> grant index 1, ack_one_hot=8'b0000_0010, ack_wrapped=1.
- ack_ready=0 for 4 cycles with req_vec=8'b0011_0000 -> grant 4 held and rr_mask_q unchanged; on ack_ready=1, grant 4 accepted and next grant is 5.
- STICKY_EN: offer index 5 with ack_ready=0, then raise req bit 2 with the mask now favouring 2 -> grant stays 5. Without the macro -> grant switches to 2.
- RST asserted in the same cycle as an accept of index 6 -> after reset rr_mask_q=all ones; req_vec=8'hFF gives grant 0 and ack_index=0.
